// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit owning HI/LO for the multicycle MIPS datapath.
// Radix-2 Booth multiply and restoring magnitude divide, one step per clock, WIDTH+1 edges per op.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       state_dbg_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic                is_div_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic [WIDTH-1:0]    opnd_q;       // multiplicand, or divisor magnitude
    logic [2*WIDTH+1:0]  prod_q;       // {acc[WIDTH:0], multiplier, q_-1}
    logic [2*WIDTH+1:0]  prod_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    hi_q, lo_q;
    logic                busy_q, done_q, div_zero_q;

    logic [WIDTH:0]      acc_sum;
    logic [WIDTH:0]      opnd_ext;
    logic [WIDTH:0]      rem_shift;
    logic [WIDTH:0]      trial;
    logic [WIDTH-1:0]    mag_a, mag_b;
    logic [WIDTH-1:0]    quo_fix, rem_fix;

    // Magnitude of the most negative value stays 0x80..0 as an unsigned quantity.
    assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Booth step on a WIDTH+1 accumulator so -2^(WIDTH-1) multiplicands cannot overflow.
    assign opnd_ext = {opnd_q[WIDTH-1], opnd_q};
    always_comb begin
        acc_sum = prod_q[2*WIDTH+1:WIDTH+1];
        case (prod_q[1:0])
            2'b01:   acc_sum = prod_q[2*WIDTH+1:WIDTH+1] + opnd_ext;
            2'b10:   acc_sum = prod_q[2*WIDTH+1:WIDTH+1] - opnd_ext;
            default: acc_sum = prod_q[2*WIDTH+1:WIDTH+1];
        endcase
        prod_d = {acc_sum[WIDTH], acc_sum, prod_q[WIDTH:1]};
    end

    // Restoring divide: quotient register doubles as the dividend shifter.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, opnd_q};
    always_comb begin
        rem_d = rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            opnd_q     <= '0;
            prod_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_mult) begin
                        state_q  <= S_MULT;
                        cnt_q    <= '0;
                        is_div_q <= 1'b0;
                        opnd_q   <= a;
                        prod_q   <= {{(WIDTH+1){1'b0}}, b, 1'b0};
                        busy_q   <= 1'b1;
                    end else if (start_div) begin
                        if (b == '0) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            state_q   <= S_DIV;
                            cnt_q     <= '0;
                            is_div_q  <= 1'b1;
                            neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_rem_q <= a[WIDTH-1];
                            opnd_q    <= mag_b;
                            rem_q     <= '0;
                            quo_q     <= mag_a;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                S_MULT: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) state_q <= S_FINISH;
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) state_q <= S_FINISH;
                end
                S_FINISH: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_q[2*WIDTH:WIDTH+1];
                        lo_q <= prod_q[WIDTH:1];
                    end
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_zero    = div_zero_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: results, latency, divide-by-zero, ignored starts, mid-op reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero;
    logic [1:0]  state_dbg;
    int          checks = 0;
    int          errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div_zero(div_zero), .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    // Drives one start edge; returns at #1 after it.
    task automatic launch(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
        start_mult = m; start_div = d; a = av; b = bv;
        @(posedge clk); #1;
        start_mult = 1'b0; start_div = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Counts edges after the start edge until done, bounded at 100.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = busy ? 1 : 0;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (done) break;
            if (busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset hi: got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset lo: got %h want %h", lo, 32'h0); end
        checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b want 000", {busy, done, div_zero}); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset state: got %0d want 0", state_dbg); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult_basic();
        int e, bc;
        launch(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult busy after start: got %b want 1", busy); end
        wait_done(e, bc);
        checks++; if (e != 33) begin errors++; $display("FAIL mult latency: got %0d want 33", e); end
        checks++; if (bc != 33) begin errors++; $display("FAIL mult busy cycles: got %0d want 33", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult busy at done: got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult 7*-3 hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult 7*-3 lo: got %h want ffffffeb", lo); end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        launch(1'b1, 1'b0, 32'h80000000, 32'h80000000);
        wait_done(e, bc);
        checks++; if (hi !== 32'h40000000) begin errors++; $display("FAIL mult min*min hi: got %h want 40000000", hi); end
        checks++; if (lo !== 32'h00000000) begin errors++; $display("FAIL mult min*min lo: got %h want 00000000", lo); end
        // Start issued in the done cycle must be accepted.
        launch(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b accept busy: got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done pulse width: got %b want 0", done); end
        wait_done(e, bc);
        checks++; if (e != 33) begin errors++; $display("FAIL b2b latency: got %0d want 33", e); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult -1*-1 hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h1) begin errors++; $display("FAIL mult -1*-1 lo: got %h want 00000001", lo); end
    endtask

    task automatic test_div_signs();
        int e, bc;
        launch(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(e, bc);
        checks++; if (e != 33) begin errors++; $display("FAIL div latency: got %0d want 33", e); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div -7/2 lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div -7/2 hi: got %h want ffffffff", hi); end
        launch(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE);
        wait_done(e, bc);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div 7/-2 lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL div 7/-2 hi: got %h want 00000001", hi); end
    endtask

    task automatic test_div_zero();
        launch(1'b0, 1'b1, 32'd123, 32'd0);
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divzero pulse: got %b want 1", div_zero); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL divzero busy/done: got %b want 00", {busy, done}); end
        @(posedge clk); #1;
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divzero width: got %b want 0", div_zero); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL divzero later busy/done: got %b want 00", {busy, done}); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL divzero hi kept: got %h want 00000001", hi); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL divzero lo kept: got %h want fffffffd", lo); end
    endtask

    task automatic test_div_corner();
        int e, bc;
        launch(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(e, bc);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div min/-1 lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div min/-1 hi: got %h want 00000000", hi); end
        launch(1'b0, 1'b1, 32'd5, 32'd7);
        wait_done(e, bc);
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL div 5/7 lo: got %h want 00000000", lo); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL div 5/7 hi: got %h want 00000005", hi); end
    endtask

    task automatic test_ignored_start();
        int e, bc, total;
        launch(1'b1, 1'b0, 32'd100, 32'd3);
        total = 0;
        repeat (9) begin @(posedge clk); #1; total++; end
        start_div = 1'b1; a = 32'd50; b = 32'd5;
        @(posedge clk); #1; total++;
        start_div = 1'b0;
        checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL ignored start state: got %0d want 1", state_dbg); end
        wait_done(e, bc);
        total += e;
        checks++; if (total != 33) begin errors++; $display("FAIL ignored start latency: got %0d want 33", total); end
        checks++; if (lo !== 32'd300) begin errors++; $display("FAIL mult 100*3 lo: got %h want 0000012c", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mult 100*3 hi: got %h want 00000000", hi); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        launch(1'b1, 1'b0, 32'd100, 32'd3);
        repeat (19) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midreset hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset lo: got %h want 00000000", lo); end
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midreset activity after: got %0d want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_back_to_back();
        test_div_signs();
        test_div_zero();
        test_div_corner();
        test_ignored_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide unit for the multicycle MIPS datapath.
- Owns the HI and LO registers.
- Its hi/lo outputs feed the register write-data mux for mfhi/mflo write-back.
- Control starts an operation, stalls on busy, and advances on done; div_zero feeds the exception logic.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH. Only 32 is used in the CPU.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start_mult  input  1  request signed multiply of a*b; sampled only in IDLE
start_div  input  1  request signed divide a/b; sampled only in IDLE
a  input  WIDTH  operand rs (multiplicand / dividend)
b  input  WIDTH  operand rt (multiplier / divisor)
hi  output  WIDTH  HI register: product[63:32] or remainder
lo  output  WIDTH  LO register: product[31:0] or quotient
busy  output  1  operation in progress
done  output  1  one-cycle pulse; hi/lo hold the new result
div_zero  output  1  one-cycle pulse; divide with b==0 was rejected

Behaviour:
- Reset, taken at the clock edge while reset=1: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
- Reset overrides everything, including mid-operation; any partial result is discarded.
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - start_mult=1 at an edge: capture a and b, go to MULT, counter=0, busy=1.
  - start_div=1 with b!=0: capture a and b, go to DIV, counter=0, busy=1.
  - start_div=1 with b==0: stay in IDLE; div_zero=1 for exactly one cycle after that edge; hi/lo unchanged; done not asserted.
  - start_mult and start_div both 1: multiply wins and start_div is ignored.
- Starts while not in IDLE are ignored with no queuing. This includes the FINISH cycle; starts are accepted again from the cycle in which done=1.
- MULT:
  - Radix-2 Booth, one step per edge, on a 2*WIDTH+1 internal product.
  - After step WIDTH-1 (counter==WIDTH-1), go to FINISH.
- DIV:
  - Restoring divide on operand magnitudes |a| and |b|, one quotient bit per edge.
  - After WIDTH steps, go to FINISH.
- FINISH, one edge:
  - Write hi/lo and go to IDLE with done=1 and busy=0 for one cycle.
  - Divide sign fix is applied here: quotient is negated if sign(a)!=sign(b); remainder takes the sign of a.
  - Quotient truncates toward zero (MIPS semantics).
- Latency: done goes high WIDTH+1 edges after the start edge (33 for WIDTH=32). busy is high for WIDTH+1 cycles in between.
- hi/lo change only on the FINISH edge or on reset. They hold between operations, so mfhi/mflo always read the last completed result.
- Multiply result is the full signed 2*WIDTH-bit product: hi=upper half, lo=lower half.
- Overflow case, divide of -2^(WIDTH-1) by -1: magnitudes give quotient 2^(WIDTH-1). Result is lo=0x80000000 (wraps), hi=0. No flag.
- Magnitude of -2^(WIDTH-1) is taken as an unsigned WIDTH-bit value (0x80000000), never sign-extended.
- Operand inputs a and b are don't-care after the start edge.

Test Plan:
- Reset, then start_mult with a=7, b=0xFFFFFFFD (-3) -> busy=1 for 33 cycles; done at edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- start_mult with a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Follow with start_mult a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1.
- start_div with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- With hi/lo holding a prior result, start_div with b=0 -> div_zero high for exactly the next cycle; busy and done stay 0; hi/lo unchanged.
- start_div with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Also start_div a=5, b=7 -> lo=0, hi=5.
- start_mult 100*3, then pulse start_div at cycle 10 -> ignored; reset at cycle 20 of a second multiply -> next cycle busy=0, hi=lo=0, no done pulse follows.
